// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : led_fader
//  Purpose  : Four-channel PWM cross-fader. The selected LED ramps to full
//             brightness while all others ramp to off, one level per fade
//             step. Brightness is rendered by an 8-bit free-running PWM with
//             period-aligned duty reloads.
//  Options  : define LED_FADER_GAMMA_EN to apply a square-law (level^2 >> 8)
//             gamma curve to the duty reload value.
//  Revision : 1.0 - initial release
// ============================================================================
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 11719
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] led_sel,
  input  logic       enable,
  output logic [3:0] pwm_out,
  output logic       busy
);

  localparam int                  STEP_W    = $clog2(STEP_DIV);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

  // Input synchronizers plus one extra stage holding the previous sample
  logic [1:0] sel_s1, sel_s2, sel_s3, sel_q;
  logic       en_s1, en_s2, en_s3, enable_q;

  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [PWM_BITS-1:0] level  [4];
  logic [PWM_BITS-1:0] target [4];
  logic [PWM_BITS-1:0] duty   [4];
  logic [PWM_BITS-1:0] reload [4];
  logic [3:0]          mismatch;

  // Synchronize inputs; accept a sel/enable pair only once it is seen twice in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_s1   <= 2'd0;
      sel_s2   <= 2'd0;
      sel_s3   <= 2'd0;
      sel_q    <= 2'd0;
      en_s1    <= 1'b0;
      en_s2    <= 1'b0;
      en_s3    <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      sel_s1 <= led_sel;
      sel_s2 <= sel_s1;
      sel_s3 <= sel_s2;
      en_s1  <= enable;
      en_s2  <= en_s1;
      en_s3  <= en_s2;
      // A transient code during a multi-bit change never matches its neighbour
      if ((sel_s2 == sel_s3) && (en_s2 == en_s3)) begin
        sel_q    <= sel_s2;
        enable_q <= en_s2;
      end
    end
  end

  // Per-channel targets and level-vs-target mismatch flags
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      target[i] = '0;
      if (enable_q && (sel_q == 2'(i))) begin
        target[i] = LEVEL_MAX;
      end
      mismatch[i] = (level[i] != target[i]);
    end
  end

  // Fade-step prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + 1'b1;
    end
  end

  assign step_tick = (step_cnt == STEP_LAST);

  // Move each level one step toward its target; targets are 0 or max so no wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        level[i] <= '0;
      end
    end else if (step_tick) begin
      for (int i = 0; i < 4; i++) begin
        if (level[i] < target[i]) begin
          level[i] <= level[i] + 1'b1;
        end else if (level[i] > target[i]) begin
          level[i] <= level[i] - 1'b1;
        end
      end
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] square [4];

  // Square-law gamma: upper half of level * level
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      square[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
      reload[i] = square[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  // Linear brightness: duty follows the level directly
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      reload[i] = level[i];
    end
  end
`endif

  // Free-running PWM counter with shadow duty reloaded only at period end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        duty[i] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // Non-blocking read of level means a coincident step tick loads the old level
      if (pwm_cnt == LEVEL_MAX) begin
        for (int i = 0; i < 4; i++) begin
          duty[i] <= reload[i];
        end
      end
    end
  end

  // Registered pin drive and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pwm_out[i] <= (duty[i] > pwm_cnt);
      end
      busy <= |mismatch;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_fader
//  Purpose  : Self-checking bench for led_fader (STEP_DIV = 4). A behavioural
//             reference predicts pwm_out and busy every cycle from cycle-count
//             arithmetic and integer brightness levels; directed scenarios
//             cover ramp, cross-fade, reversal, skew filtering, period-aligned
//             duty changes and mid-fade reset, followed by random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_fader;

  localparam int PWM_BITS = 8;
  localparam int STEP_DIV = 4;
  localparam int MAXL     = 255;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [1:0] led_sel = 2'd0;
  logic       enable  = 1'b0;
  logic [3:0] pwm_out;
  logic       busy;

  led_fader #(
    .PWM_BITS(PWM_BITS),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .led_sel(led_sel),
    .enable (enable),
    .pwm_out(pwm_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned cyc;            // edges since reset release
  logic [2:0]  hist [3];       // {enable,led_sel} seen 1, 2, 3 edges ago
  logic [1:0]  m_sel;
  logic        m_en;
  int          m_level [4];
  int          m_duty  [4];
  logic [3:0]  m_pwm;
  logic        m_busy;
  logic [3:0]  prev_pwm;
  int          rises_off_boundary = 0;

  function automatic int brightness(input int lvl);
`ifdef LED_FADER_GAMMA_EN
    return (lvl * lvl) >> 8;
`else
    return lvl;
`endif
  endfunction

  task automatic model_reset();
    cyc    = 0;
    m_sel  = 2'd0;
    m_en   = 1'b0;
    m_pwm  = 4'b0;
    m_busy = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 3'b0;
    for (int i = 0; i < 4; i++) begin
      m_level[i] = 0;
      m_duty[i]  = 0;
    end
  endtask

  // Advance the reference by one rising edge, using the state before the edge
  task automatic model_step();
    int tgt [4];
    int phase_step;
    int phase_pwm;
    if (!rst_n) begin
      model_reset();
      return;
    end
    phase_step = int'(cyc % STEP_DIV);
    phase_pwm  = int'(cyc % 256);
    for (int i = 0; i < 4; i++) tgt[i] = (m_en && (m_sel == 2'(i))) ? MAXL : 0;
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) if (m_level[i] != tgt[i]) m_busy = 1'b1;
    for (int i = 0; i < 4; i++) m_pwm[i] = (m_duty[i] > phase_pwm);
    if (phase_pwm == 255) begin
      for (int i = 0; i < 4; i++) m_duty[i] = brightness(m_level[i]);
    end
    if (phase_step == STEP_DIV - 1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_level[i] < tgt[i]) m_level[i] = m_level[i] + 1;
        else if (m_level[i] > tgt[i]) m_level[i] = m_level[i] - 1;
      end
    end
    if (hist[1] == hist[2]) {m_en, m_sel} = hist[1];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {enable, led_sel};
    cyc++;
  endtask

  // One clock: model on the rising edge, compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pwm_out", pwm_out, m_pwm);
    check("busy", busy, m_busy);
    if (rst_n && cyc > 0 && ((pwm_out & ~prev_pwm) != 4'b0) && ((cyc - 1) % 256 != 0))
      rises_off_boundary++;
    prev_pwm = pwm_out;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt [4];
    int prev0, cur0, d, min0;
    bit switched, seen0;
    int lvl0max;

    model_reset();
    prev_pwm = 4'b0;

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_pwm_out", pwm_out, 4'b0);
    check("rst_busy", busy, 1'b0);
    run(3);
    rst_n = 1'b1;
    run(10);

    // Ramp LED 2 up: sampled on the 1st edge, captured on the 4th, busy on the 5th
    enable  = 1'b1;
    led_sel = 2'd2;
    n = 0;
    while (!busy && n < 20) begin cycle(); n++; end
    check("busy_rise_edges", n, 5);
    n = 0;
    while (busy && n < 1100) begin cycle(); n++; end
    check("ramp_len_in_range", (n >= 1017 && n <= 1020), 1'b1);
    check("level2_full", dut.level[2], MAXL);

    // Full-brightness PWM pattern over one period
    run(600);
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 256; k++) begin
      cycle();
      for (int i = 0; i < 4; i++) cnt[i] += int'(pwm_out[i]);
    end
    check("ch2_high_cycles", cnt[2], brightness(MAXL));
    check("ch0_high_cycles", cnt[0], 0);
    check("ch1_high_cycles", cnt[1], 0);
    check("ch3_high_cycles", cnt[3], 0);

    // Cross-fade 2 -> 3: levels move in lockstep, sum constant
    led_sel = 2'd3;
    for (n = 0; n < 1200; n++) begin
      cycle();
      check("xfade_sum", int'(dut.level[2]) + int'(dut.level[3]), MAXL);
      if (n > 10 && !busy) break;
    end
    check("xfade_l3", dut.level[3], MAXL);
    check("xfade_l2", dut.level[2], 0);

    // Reversal: select 0, at 100 select 1, at 90 select 0 again
    led_sel = 2'd0;
    n = 0;
    while (dut.level[0] != 8'd100 && n < 600) begin cycle(); n++; end
    check("rev_reach100", dut.level[0], 100);
    led_sel  = 2'd1;
    switched = 1'b0;
    prev0    = 100;
    min0     = 100;
    for (n = 0; n < 1000; n++) begin
      cycle();
      cur0 = int'(dut.level[0]);
      if (cur0 != prev0) begin
        d = cur0 - prev0;
        if (d < 0) d = -d;
        check("rev_step_size", d, 1);
      end
      if (cur0 < min0) min0 = cur0;
      prev0 = cur0;
      if (!switched && cur0 == 90) begin
        led_sel  = 2'd0;
        switched = 1'b1;
      end
      if (switched && cur0 == 120) break;
    end
    check("rev_went_down", (min0 < 100), 1'b1);
    check("rev_climbed_back", dut.level[0], 120);

    // Settle on LED 1
    led_sel = 2'd1;
    n = 0;
    while ((busy || n < 10) && n < 1200) begin cycle(); n++; end
    check("settle_l1", dut.level[1], MAXL);

    // Skew filter: one-cycle glitch to 0 between 1 and 2 is never captured
    led_sel = 2'd0;
    cycle();
    led_sel = 2'd2;
    seen0   = 1'b0;
    lvl0max = 0;
    for (n = 0; n < 1200; n++) begin
      cycle();
      if (dut.sel_q == 2'd0) seen0 = 1'b1;
      if (int'(dut.level[0]) > lvl0max) lvl0max = int'(dut.level[0]);
      if (n > 10 && !busy) break;
    end
    check("skew_sel0_seen", seen0, 1'b0);
    check("skew_level0_max", lvl0max, 0);
    check("skew_sel_final", dut.sel_q, 2'd2);

    // Mid-fade reset at level[1] = 37
    led_sel = 2'd1;
    n = 0;
    while (dut.level[1] != 8'd37 && n < 400) begin cycle(); n++; end
    check("mid_reach37", dut.level[1], 37);
    check("busy_before_reset", busy, 1'b1);
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("midrst_pwm_out", pwm_out, 4'b0);
    check("midrst_busy", busy, 1'b0);
    run(3);
    rst_n = 1'b1;
    run(300);
    check("idle_busy", busy, 1'b0);
    check("idle_pwm_out", pwm_out, 4'b0);

    // Random select/enable with random hold times, including short pulses
    for (int s = 0; s < 80; s++) begin
      led_sel = 2'($urandom_range(0, 3));
      enable  = ($urandom_range(0, 3) != 0);
      run(int'($urandom_range(1, 60)));
    end

    check("pwm_rise_only_at_period_start", rises_off_boundary, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
